// File: rtl/ones_counter_pkg.sv
// Shared definitions for the population-count block: default word width and
// the helper that sizes a count able to hold the full word width.
package ones_counter_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  // Width of an unsigned count that can represent values 0..w inclusive.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/ones_counter_popcount_tree.sv
// Combinational balanced adder tree that counts the '1' bits of a word.
// The word is split in two halves, each half is counted by a recursive
// instance, and the two partial counts are added. Each level of the tree is
// one bit wider than the level below it, so depth grows as log2(DATA_WIDTH).
module popcount_tree
  import ones_counter_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  localparam int CNT_W = cnt_width(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] bits,
  output logic [CNT_W-1:0]      count
);

  generate
    if (DATA_WIDTH == 1) begin : g_leaf
      // A single bit is its own count.
      assign count = bits;
    end else begin : g_split
      // Lower half takes floor(W/2) bits so the upper half is never smaller;
      // the upper half's count is therefore exactly one bit narrower than ours.
      localparam int LO_W  = DATA_WIDTH / 2;
      localparam int HI_W  = DATA_WIDTH - LO_W;
      localparam int LO_CW = cnt_width(LO_W);
      localparam int HI_CW = cnt_width(HI_W);

      logic [LO_CW-1:0] lo_cnt;
      logic [HI_CW-1:0] hi_cnt;

      popcount_tree #(
        .DATA_WIDTH (LO_W)
      ) u_lo (
        .bits  (bits[LO_W-1:0]),
        .count (lo_cnt)
      );

      popcount_tree #(
        .DATA_WIDTH (HI_W)
      ) u_hi (
        .bits  (bits[DATA_WIDTH-1:LO_W]),
        .count (hi_cnt)
      );

      // Both partial counts are zero-extended before the add; the sum of the
      // two halves never exceeds DATA_WIDTH, which fits in CNT_W bits.
      assign count = CNT_W'(lo_cnt) + CNT_W'(hi_cnt);
    end
  endgenerate

endmodule

// File: rtl/ones_counter_pipe.sv
// Registered population count: one word per cycle in, its bit count plus
// all-zero / all-ones flags out one cycle later with a valid strobe.
// The last result is held while no new word arrives.
module ones_counter_pipe
  import ones_counter_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  localparam int CNT_W = cnt_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  din_valid,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [CNT_W-1:0]      dout,
  output logic                  dout_valid,
  output logic                  all_zero,
  output logic                  all_ones
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_WIDTH);

  // Flag for a count of zero.
  function automatic logic is_empty(input logic [CNT_W-1:0] c);
    return (c == '0);
  endfunction

  // Flag for a count equal to the full word width.
  function automatic logic is_full(input logic [CNT_W-1:0] c);
    return (c == FULL_CNT);
  endfunction

  // ---- stage p0: combinational count of the incoming word ----
  logic [CNT_W-1:0] cnt_p0;
  logic             vld_p0;

  assign vld_p0 = din_valid;

  popcount_tree #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_tree (
    .bits  (din),
    .count (cnt_p0)
  );

  // ---- stage p1: output registers ----
  logic [CNT_W-1:0] cnt_p1;
  logic             vld_p1;
  logic             zero_p1;
  logic             ones_p1;

  // Valid strobe follows din_valid by one cycle; reset wins over new data.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
    end
  end

  // Count and flags load only on a valid word and otherwise keep the last
  // result, so din is ignored entirely while din_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p1  <= '0;
      zero_p1 <= 1'b0;
      ones_p1 <= 1'b0;
    end else if (vld_p0) begin
      cnt_p1  <= cnt_p0;
      zero_p1 <= is_empty(cnt_p0);
      ones_p1 <= is_full(cnt_p0);
    end
  end

  assign dout       = cnt_p1;
  assign dout_valid = vld_p1;
  assign all_zero   = zero_p1;
  assign all_ones   = ones_p1;

endmodule

// File: tb/tb_ones_counter_pipe.sv
// Directed bench for ones_counter_pipe at width 8, plus width 1/5/32 copies
// driven with all-ones and random words against a $countones reference.
module tb_ones_counter_pipe;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // 8-bit instance
  logic       v8;
  logic [7:0] d8;
  logic [3:0] q8;
  logic       qv8, z8, o8;

  ones_counter_pipe #(.DATA_WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .din_valid(v8), .din(d8),
    .dout(q8), .dout_valid(qv8), .all_zero(z8), .all_ones(o8)
  );

  // 1-bit instance
  logic       v1;
  logic [0:0] d1;
  logic [0:0] q1;
  logic       qv1, z1, o1;

  ones_counter_pipe #(.DATA_WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .din_valid(v1), .din(d1),
    .dout(q1), .dout_valid(qv1), .all_zero(z1), .all_ones(o1)
  );

  // 5-bit instance
  logic       v5;
  logic [4:0] d5;
  logic [3:0] q5;
  logic       qv5, z5, o5;

  ones_counter_pipe #(.DATA_WIDTH(5)) u_dut5 (
    .clk(clk), .rst(rst), .din_valid(v5), .din(d5),
    .dout(q5), .dout_valid(qv5), .all_zero(z5), .all_ones(o5)
  );

  // 32-bit instance
  logic        v32;
  logic [31:0] d32;
  logic [5:0]  q32;
  logic        qv32, z32, o32;

  ones_counter_pipe #(.DATA_WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .din_valid(v32), .din(d32),
    .dout(q32), .dout_valid(qv32), .all_zero(z32), .all_ones(o32)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input int cnt, input bit vld, input bit z, input bit o);
    chk({tag, ".dout"}, 64'(q8), 64'(cnt));
    chk({tag, ".vld"},  64'(qv8), 64'(vld));
    chk({tag, ".zero"}, 64'(z8), 64'(z));
    chk({tag, ".ones"}, 64'(o8), 64'(o));
  endtask

  // Reference state for the width sweep (sticky last result).
  int  e1, e5, e32;
  bit  ez1, eo1, ez5, eo5, ez32, eo32;

  initial begin
    logic [8:0] ramp;
    logic [7:0] pats [3];
    int         pcnt [3];

    rst = 1'b1;
    v8 = 1'b1; d8 = 8'hFF;
    v1 = 1'b0; d1 = '0;
    v5 = 1'b0; d5 = '0;
    v32 = 1'b0; d32 = '0;
    #1;

    // Reset held for two cycles with a valid all-ones word presented.
    for (int i = 0; i < 2; i++) begin
      tick();
      chk8($sformatf("rst%0d", i), 0, 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b0; v8 = 1'b0;
    tick();
    chk8("rst_rel", 0, 1'b0, 1'b0, 1'b0);

    // Ramp: 0..8 ones back to back.
    for (int k = 0; k <= 8; k++) begin
      ramp = (9'd1 << k) - 9'd1;
      v8 = 1'b1; d8 = ramp[7:0];
      tick();
      chk8($sformatf("ramp%0d", k), k, 1'b1, k == 0, k == 8);
    end
    v8 = 1'b0; d8 = 8'h00;
    tick();
    chk8("ramp_end", 8, 1'b0, 1'b0, 1'b1);

    // Hold: one word, then idle cycles with garbage on din.
    v8 = 1'b1; d8 = 8'b1011_0010;
    tick();
    chk8("hold_load", 4, 1'b1, 1'b0, 1'b0);
    v8 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d8 = 8'($urandom);
      tick();
      chk8($sformatf("hold%0d", i), 4, 1'b0, 1'b0, 1'b0);
    end

    // Scattered patterns on alternating cycles.
    pats[0] = 8'hA5; pcnt[0] = 4;
    pats[1] = 8'h80; pcnt[1] = 1;
    pats[2] = 8'h7E; pcnt[2] = 6;
    for (int i = 0; i < 3; i++) begin
      v8 = 1'b1; d8 = pats[i];
      tick();
      chk8($sformatf("scat%0d", i), pcnt[i], 1'b1, 1'b0, 1'b0);
      v8 = 1'b0; d8 = ~pats[i];
      tick();
      chk8($sformatf("scat%0d_idle", i), pcnt[i], 1'b0, 1'b0, 1'b0);
    end

    // Load an all-ones result, then a valid word coincident with reset.
    v8 = 1'b1; d8 = 8'hFF;
    tick();
    chk8("pre_mid", 8, 1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    chk8("mid_rst", 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; v8 = 1'b0;
    tick();
    chk8("mid_rel", 0, 1'b0, 1'b0, 1'b0);

    // Width sweep: all-ones word into each instance.
    v1 = 1'b1; d1 = '1;
    v5 = 1'b1; d5 = '1;
    v32 = 1'b1; d32 = '1;
    tick();
    chk("w1_full.dout", 64'(q1), 64'd1);
    chk("w1_full.ones", 64'(o1), 64'd1);
    chk("w1_full.zero", 64'(z1), 64'd0);
    chk("w5_full.dout", 64'(q5), 64'd5);
    chk("w5_full.ones", 64'(o5), 64'd1);
    chk("w5_full.zero", 64'(z5), 64'd0);
    chk("w32_full.dout", 64'(q32), 64'd32);
    chk("w32_full.ones", 64'(o32), 64'd1);
    chk("w32_full.zero", 64'(z32), 64'd0);
    e1 = 1; ez1 = 1'b0; eo1 = 1'b1;
    e5 = 5; ez5 = 1'b0; eo5 = 1'b1;
    e32 = 32; ez32 = 1'b0; eo32 = 1'b1;

    // Random words with random valid against a $countones reference.
    for (int n = 0; n < 1000; n++) begin
      v1 = 1'($urandom);  d1 = 1'($urandom);
      v5 = 1'($urandom);  d5 = 5'($urandom);
      v32 = 1'($urandom); d32 = $urandom;
      if (n % 7 == 0) d32 = 32'h0;
      if (n % 11 == 0) d5 = 5'h1F;
      if (v1) begin
        e1 = $countones(d1); ez1 = (e1 == 0); eo1 = (e1 == 1);
      end
      if (v5) begin
        e5 = $countones(d5); ez5 = (e5 == 0); eo5 = (e5 == 5);
      end
      if (v32) begin
        e32 = $countones(d32); ez32 = (e32 == 0); eo32 = (e32 == 32);
      end
      tick();
      chk("w1_rnd.dout", 64'(q1), 64'(e1));
      chk("w1_rnd.vld",  64'(qv1), 64'(v1));
      chk("w1_rnd.zero", 64'(z1), 64'(ez1));
      chk("w1_rnd.ones", 64'(o1), 64'(eo1));
      chk("w5_rnd.dout", 64'(q5), 64'(e5));
      chk("w5_rnd.vld",  64'(qv5), 64'(v5));
      chk("w5_rnd.zero", 64'(z5), 64'(ez5));
      chk("w5_rnd.ones", 64'(o5), 64'(eo5));
      chk("w32_rnd.dout", 64'(q32), 64'(e32));
      chk("w32_rnd.vld",  64'(qv32), 64'(v32));
      chk("w32_rnd.zero", 64'(z32), 64'(ez32));
      chk("w32_rnd.ones", 64'(o32), 64'(eo32));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ones_counter_pipe.md
Name: ones_counter_pipe

Overview:
- Registered population-count block: counts the number of '1' bits in a DATA_WIDTH-bit input word.
- Presents the count one clock later, with a valid strobe and all-zero/all-ones flags.
- Used wherever a bit-occupancy count is needed, e.g. mask weight or active-lane count.
- Sits downstream of any valid-qualified data source; no back-pressure.

Parameters:
- DATA_WIDTH, 8, input word width in bits; legal range 1..256.
- CNT_W (derived, localparam), $clog2(DATA_WIDTH)+1, count width; always wide enough to hold the value DATA_WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- din_valid  input  1  din is sampled on this cycle
- din  input  DATA_WIDTH  word to count
- dout  output  CNT_W  number of '1' bits in the last sampled word
- dout_valid  output  1  one-cycle strobe; dout was updated this cycle
- all_zero  output  1  last sampled word had count 0
- all_ones  output  1  last sampled word had count DATA_WIDTH

Behaviour:
- Clocking and reset:
  - Single clock domain; all state updates on the rising edge of clk.
  - rst is synchronous, active-high, and takes priority over din_valid.
  - Reset values: dout=0, dout_valid=0, all_zero=0, all_ones=0.
- Count path:
  - Combinational popcount of din: sum over i of din[i].
  - Computed unsigned at CNT_W bits; no overflow is possible.
- Latency:
  - Exactly 1 cycle.
  - If din_valid=1 at edge N, then after edge N: dout=popcount(din), dout_valid=1, all_zero=(popcount==0), all_ones=(popcount==DATA_WIDTH).
- Idle cycles:
  - If din_valid=0 at an edge: dout_valid goes 0.
  - dout, all_zero and all_ones hold their previous values (sticky last result).
- Throughput: one word per cycle; back-to-back din_valid is fully supported.
- Handshake: no ready signal. Consumers must capture dout while dout_valid=1, or rely on the hold behaviour.
- X handling: din is don't-care when din_valid=0 and must not affect any register.
- Boundary cases:
  - DATA_WIDTH=1: CNT_W=1; dout equals din[0]; all_zero and all_ones are mutually exclusive.
  - DATA_WIDTH not a power of two (e.g. 5): CNT_W=$clog2(5)+1=4; maximum count 5.
  - all_zero and all_ones are never both 1, since DATA_WIDTH ≥ 1.
- Reset mid-stream:
  - A word presented in the same cycle as rst is discarded.
  - The next cycle shows reset values.
- Combinational structure:
  - Balanced adder tree: pairwise sums of bits, then of partial sums, with widths growing by 1 per level.
  - This keeps depth at ~log2(DATA_WIDTH) levels.
  - A linear ripple sum is not acceptable for DATA_WIDTH > 32.

Decomposition:
- Shared package ones_counter_pkg:
  - function cnt_width(int w) returning $clog2(w)+1;
  - default DATA_WIDTH constant.
- One sub-module: popcount_tree.
  - Purely combinational: input [DATA_WIDTH-1:0] bits, output [CNT_W-1:0] count.
  - Implemented as a recursive or generate-based adder tree.
  - Instantiated once inside ones_counter_pipe.
- ones_counter_pipe itself holds only the output registers, valid register and flag logic.

Test Plan:
- Reset: assert rst 2 cycles with din_valid=1, din=8'hFF -> dout=0, dout_valid=0, all_zero=0, all_ones=0 throughout and one cycle after release.
- Ramp: back-to-back din_valid with din=00000000, 00000001, 00000011, … 11111111 (9 words) -> dout=0,1,2,…,8 on consecutive cycles, each one cycle after input.
  - dout_valid=1 for 9 consecutive cycles.
  - all_zero=1 only for the first result; all_ones=1 only for the last.
- Hold: din=8'b10110010 valid once, then din_valid=0 with din toggling randomly for 5 cycles -> dout=4 held, dout_valid=1 for one cycle then 0.
- Scattered patterns: din=8'hA5 -> 4, 8'h80 -> 1, 8'h7E -> 6.
  - Each is valid on alternating cycles; dout_valid pulses only on the cycles after a valid input.
- Reset mid-stream: din=8'hFF valid with rst=1 in the same cycle -> next cycle dout=0, dout_valid=0, all_ones=0.
- Parameter sweep: DATA_WIDTH=1, 5, 32; all-ones input -> dout=1, 5, 32 with all_ones=1.
  - Random inputs (1000 each) match a reference $countones model.
